// File: rtl/riscv_core_immgen_pkg.sv
// Shared types and field widths for the pipelined immediate generator.
package riscv_core_immgen_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned IMMSRC_W = 4;
    localparam int unsigned RVC_W    = 16;

    // Width of each immediate before extension (sign bit included)
    localparam int unsigned IMM_I_W       = 12;
    localparam int unsigned IMM_S_W       = 12;
    localparam int unsigned IMM_B_W       = 13;
    localparam int unsigned IMM_J_W       = 21;
    localparam int unsigned IMM_U_W       = 32;
    localparam int unsigned IMM_CSR_W     = 5;
    localparam int unsigned IMM_SHAMT64_W = 6;
    localparam int unsigned IMM_SHAMT32_W = 5;
    localparam int unsigned IMM_CI_W      = 6;
    localparam int unsigned IMM_CJ_W      = 12;
    localparam int unsigned IMM_CB_W      = 9;
    localparam int unsigned IMM_CIW_W     = 10;
    localparam int unsigned IMM_CLD_W     = 8;

    typedef enum logic [IMMSRC_W-1:0] {
        IMM_I     = 4'd0,
        IMM_S     = 4'd1,
        IMM_B     = 4'd2,
        IMM_J     = 4'd3,
        IMM_U     = 4'd4,
        IMM_CSR   = 4'd5,
        IMM_SHAMT = 4'd6,
        IMM_RSVD7 = 4'd7,
        IMM_C_CI  = 4'd8,
        IMM_C_CJ  = 4'd9,
        IMM_C_CB  = 4'd10,
        IMM_C_CIW = 4'd11,
        IMM_C_CLD = 4'd12
    } immsrc_e;

endpackage

// File: rtl/riscv_core_immgen_decode.sv
// Combinational immediate decode: instruction + format select -> extended immediate.
// RVC formats (codes 8-12) are decoded only when RISCV_CORE_IMMGEN_RVC_EN is defined.
module riscv_core_immgen_decode
    import riscv_core_immgen_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INSTR_W-1:0]  i_instr,
    input  logic [IMMSRC_W-1:0] i_immsrc,
    output logic [XLEN-1:0]     o_imm_c,
    output logic                o_illegal_c
);

    // Every format fits a sign-correct 32-bit value; widening to XLEN is a signed cast.
    logic [31:0] imm32;

`ifdef RISCV_CORE_IMMGEN_RVC_EN
    logic [RVC_W-1:0] c;
    logic             unused_quadrant;
    assign c               = i_instr[RVC_W-1:0];
    assign unused_quadrant = ^i_instr[1:0];
`else
    logic unused_opcode;
    assign unused_opcode = ^i_instr[6:0];
`endif

    // Format mux; unsupported codes flag illegal and return zero
    always_comb begin
        imm32       = '0;
        o_illegal_c = 1'b0;
        case (immsrc_e'(i_immsrc))
            IMM_I:   imm32 = {{(32-IMM_I_W){i_instr[31]}}, i_instr[31:20]};
            IMM_S:   imm32 = {{(32-IMM_S_W){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_B:   imm32 = {{(32-IMM_B_W){i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            IMM_J:   imm32 = {{(32-IMM_J_W){i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            IMM_U:   imm32 = {i_instr[31:12], {(IMM_U_W-20){1'b0}}};
            IMM_CSR: imm32 = {{(32-IMM_CSR_W){1'b0}}, i_instr[19:15]};
            IMM_SHAMT: begin
                if (XLEN == 64) imm32 = {{(32-IMM_SHAMT64_W){1'b0}}, i_instr[25:20]};
                else            imm32 = {{(32-IMM_SHAMT32_W){1'b0}}, i_instr[24:20]};
            end
`ifdef RISCV_CORE_IMMGEN_RVC_EN
            IMM_C_CI:  imm32 = {{(32-IMM_CI_W){c[12]}}, c[12], c[6:2]};
            IMM_C_CJ:  imm32 = {{(32-IMM_CJ_W){c[12]}}, c[12], c[8], c[10:9], c[6],
                                c[7], c[2], c[11], c[5:3], 1'b0};
            IMM_C_CB:  imm32 = {{(32-IMM_CB_W){c[12]}}, c[12], c[6:5], c[2],
                                c[11:10], c[4:3], 1'b0};
            IMM_C_CIW: imm32 = {{(32-IMM_CIW_W){1'b0}}, c[10:7], c[12:11], c[5], c[6], 2'b00};
            IMM_C_CLD: imm32 = {{(32-IMM_CLD_W){1'b0}}, c[6:5], c[12:10], 3'b000};
`endif
            default: o_illegal_c = 1'b1;
        endcase
    end

    assign o_imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/riscv_core_immgen_pipe.sv
// Pipelined immediate generator with valid/ready handshake and a 2-entry skid buffer.
// Optional RVC decode enabled by defining RISCV_CORE_IMMGEN_RVC_EN.
module riscv_core_immgen_pipe
    import riscv_core_immgen_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
) (
    input  logic                i_immgen_clk,
    input  logic                i_immgen_rst_n,
    input  logic                i_immgen_flush,
    input  logic                i_immgen_valid,
    output logic                o_immgen_ready,
    input  logic [INSTR_W-1:0]  i_immgen_instr,
    input  logic [IMMSRC_W-1:0] i_immgen_immsrc,
    input  logic [TAG_W-1:0]    i_immgen_tag,
    output logic                o_immgen_valid,
    input  logic                i_immgen_ready,
    output logic [XLEN-1:0]     o_immgen_imm,
    output logic                o_immgen_illegal,
    output logic [TAG_W-1:0]    o_immgen_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } immgen_entry_t;

    logic          out_valid_q, out_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q, ready_d;
    immgen_entry_t out_entry_q, out_entry_d;
    immgen_entry_t skid_entry_q, skid_entry_d;
    immgen_entry_t new_entry;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            accept;
    logic            drain;

    riscv_core_immgen_decode #(.XLEN(XLEN)) u_decode (
        .i_instr     (i_immgen_instr),
        .i_immsrc    (i_immgen_immsrc),
        .o_imm_c     (dec_imm),
        .o_illegal_c (dec_illegal)
    );

    // Handshake qualifiers and the entry formed from the current request
    always_comb begin
        accept            = i_immgen_valid & ready_q & ~i_immgen_flush;
        drain             = out_valid_q & i_immgen_ready;
        new_entry.imm     = dec_imm;
        new_entry.illegal = dec_illegal;
        new_entry.tag     = i_immgen_tag;
    end

    // Output/skid next state; ready is registered and tracks skid emptiness
    always_comb begin
        out_valid_d  = out_valid_q;
        out_entry_d  = out_entry_q;
        skid_valid_d = skid_valid_q;
        skid_entry_d = skid_entry_q;
        if (i_immgen_flush) begin
            out_valid_d  = 1'b0;
            out_entry_d  = '0;
            skid_valid_d = 1'b0;
            skid_entry_d = '0;
        end else if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                // Skid full implies ready was low, so nothing was accepted this cycle
                out_valid_d  = 1'b1;
                out_entry_d  = skid_entry_q;
                skid_valid_d = 1'b0;
                skid_entry_d = '0;
            end else begin
                out_valid_d = accept;
                out_entry_d = accept ? new_entry : '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_entry_d = new_entry;
        end
        ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge i_immgen_clk) begin
        if (!i_immgen_rst_n) begin
            out_valid_q  <= 1'b0;
            out_entry_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_entry_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_entry_q  <= out_entry_d;
            skid_valid_q <= skid_valid_d;
            skid_entry_q <= skid_entry_d;
            ready_q      <= ready_d;
        end
    end

    assign o_immgen_ready   = ready_q;
    assign o_immgen_valid   = out_valid_q;
    assign o_immgen_imm     = out_entry_q.imm;
    assign o_immgen_illegal = out_entry_q.illegal;
    assign o_immgen_tag     = out_entry_q.tag;

endmodule
